// File: rtl/regfile_port_ctrl.sv
// Register-file write-port controller: post-reset init sweep, then writeback/debug arbitration.
// Optional debug requester and starvation guard enabled by `REGFILE_DBG_PORT_EN.
module regfile_port_ctrl #(
   parameter int NREGS        = 32,
   parameter int AW           = 5,
   parameter int DW           = 32,
   parameter int INIT_INDEX   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_req,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          wb_stall,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_data,
   output logic          dbg_gnt,
   output logic          we_RF,
   output logic [AW-1:0] A3,
   output logic [DW-1:0] WD3,
   output logic          pc_en,
   output logic          init_done
);

   localparam int CW = $clog2(NREGS + 1);

   typedef enum logic [1:0] {
      INIT,
      RUN
`ifdef REGFILE_DBG_PORT_EN
      , DBG_FORCE
`endif
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          we_nxt;
   logic [AW-1:0] a3_nxt;
   logic [DW-1:0] wd_nxt;

`ifdef REGFILE_DBG_PORT_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve, starve_nxt;
`else
   logic dbg_unused;
   assign dbg_unused = ^{dbg_req, dbg_addr, dbg_data};
   assign dbg_gnt    = 1'b0;
`endif

   // Both decode from the state register only, so they cannot glitch.
   assign pc_en     = (state == RUN);
   assign init_done = (state != INIT);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      we_nxt    = 1'b0;
      a3_nxt    = A3;
      wd_nxt    = WD3;
      wb_stall  = 1'b0;
`ifdef REGFILE_DBG_PORT_EN
      dbg_gnt    = 1'b0;
      starve_nxt = '0;
`endif
      unique case (state)
         INIT: begin
            wb_stall = wb_req;
            // Extra cycle at cnt==NREGS lets the last sweep write retire first.
            if (cnt == CW'(NREGS)) begin
               state_nxt = RUN;
            end else begin
               we_nxt  = 1'b1;
               a3_nxt  = AW'(cnt);
               wd_nxt  = (INIT_INDEX != 0) ? DW'(cnt) : '0;
               cnt_nxt = cnt + CW'(1);
            end
         end
         RUN: begin
            if (wb_req) begin
               we_nxt = 1'b1;
               a3_nxt = wb_addr;
               wd_nxt = wb_data;
            end
`ifdef REGFILE_DBG_PORT_EN
            else if (dbg_req) begin
               dbg_gnt = 1'b1;
               we_nxt  = 1'b1;
               a3_nxt  = dbg_addr;
               wd_nxt  = dbg_data;
            end
            if (dbg_req && wb_req) begin
               if (starve == SW'(STARVE_LIMIT - 1))
                  state_nxt = DBG_FORCE;
               else
                  starve_nxt = starve + SW'(1);
            end
`endif
         end
`ifdef REGFILE_DBG_PORT_EN
         DBG_FORCE: begin
            wb_stall  = wb_req;
            dbg_gnt   = dbg_req;
            state_nxt = RUN;
            if (dbg_req) begin
               we_nxt = 1'b1;
               a3_nxt = dbg_addr;
               wd_nxt = dbg_data;
            end
         end
`endif
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= INIT;
         cnt   <= '0;
         we_RF <= 1'b0;
         A3    <= '0;
         WD3   <= '0;
`ifdef REGFILE_DBG_PORT_EN
         starve <= '0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         we_RF <= we_nxt;
         A3    <= a3_nxt;
         WD3   <= wd_nxt;
`ifdef REGFILE_DBG_PORT_EN
         starve <= starve_nxt;
`endif
      end
   end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Controller for the register-file write port (`we_RF`/`A3`/`WD3`) in the pipelined processor.
- After reset it sweeps every register with a deterministic init value while holding the pipeline.
- It then shares the single write port between the writeback stage and an optional debug/host requester.
- Writeback has priority; a starvation guard freezes the pipeline for one cycle to service debug.

## Interface
Parameters:
- `NREGS`, 32, number of registers swept at init
- `AW`, 5, register address width
- `DW`, 32, data width
- `INIT_INDEX`, 1, 1: register i initialised to i; 0: initialised to 0
- `STARVE_LIMIT`, 4, consecutive denied debug cycles before forced grant (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `wb_req`  in  1  writeback write request
- `wb_addr`  in  AW  writeback destination register
- `wb_data`  in  DW  writeback data
- `wb_stall`  out  1  writeback request not accepted this cycle
- `dbg_req`  in  1  debug write request; held with addr/data until granted
- `dbg_addr`  in  AW  debug destination register
- `dbg_data`  in  DW  debug data
- `dbg_gnt`  out  1  debug request accepted this cycle
- `we_RF`  out  1  register-file write enable
- `A3`  out  AW  register-file write address
- `WD3`  out  DW  register-file write data
- `pc_en`  out  1  pipeline/PC enable
- `init_done`  out  1  init sweep complete

## Operation
- States: INIT, RUN, DBG_FORCE (DBG_FORCE exists only with the macro).
- Reset (`rst`=0 at an edge, from any state, including mid-sweep):
  - state INIT, sweep counter 0, starve counter 0;
  - `we_RF`=0, `A3`=0, `WD3`=0, `pc_en`=0, `init_done`=0, `dbg_gnt`=0.
- INIT:
  - each cycle registers a write: `we_RF`=1, `A3`=counter, `WD3`=counter zero-extended (`INIT_INDEX`=1) or 0.
  - Counter increments; after writing `NREGS`-1 the state goes to RUN.
  - `wb_req`/`dbg_req` are ignored; `wb_stall`=`wb_req`, `dbg_gnt`=0.
- RUN (`pc_en`=1, `init_done`=1):
  - `wb_req`=1: writeback selected, `wb_stall`=0.
  - Otherwise, `dbg_req`=1: debug selected, `dbg_gnt`=1.
  - Selected request is registered onto `we_RF`/`A3`/`WD3` at the next edge. With no selection, `we_RF`=0 and `A3`/`WD3` hold their previous values.
- Starvation:
  - Starve counter increments when `dbg_req` & !`dbg_gnt` in RUN, and clears otherwise.
  - When it would reach `STARVE_LIMIT`, next state is DBG_FORCE.
- DBG_FORCE (one cycle):
  - `pc_en`=0, `wb_stall`=`wb_req`, `dbg_gnt`=`dbg_req`.
  - Debug write registered if `dbg_req`; counter cleared; back to RUN.
- `init_done` stays 1 after the sweep until the next reset. Address 0 receives no special treatment.

## Timing
- `dbg_gnt` and `wb_stall` are combinational from current state and inputs, valid in the request cycle.
- `we_RF`/`A3`/`WD3` are registered: the write appears one cycle after acceptance.
- `pc_en` and `init_done` decode from the state register only (glitch-free).
- Init sweep:
  - first init write is visible in the cycle after the first edge with `rst`=1;
  - `NREGS` consecutive write cycles;
  - `pc_en`=`init_done`=1 from cycle `NREGS`+1.
- With `wb_req` and `dbg_req` both held continuously: writeback is accepted for `STARVE_LIMIT` cycles, then debug is accepted in the next cycle (`pc_en`=0), then writeback resumes.
- Simultaneous reset and request: reset wins and the request is dropped.

## Configuration
- `REGFILE_DBG_PORT_EN` defined: debug requester, starve counter and DBG_FORCE are compiled in as described.
- Not defined:
  - `dbg_*` inputs are ignored and `dbg_gnt` is tied 0;
  - no starve counter; DBG_FORCE does not exist;
  - `pc_en` = (state==RUN);
  - ports remain present.

## Test plan
- Release reset → `we_RF`=1 for 32 cycles with `A3`=`WD3`=0..31 (`INIT_INDEX`=1), `pc_en`=0; the following cycle `pc_en`=`init_done`=1, `we_RF`=0.
- RUN, `wb_req`=1, addr 7, data 0xDEADBEEF → `wb_stall`=0; next cycle `we_RF`=1, `A3`=7, `WD3`=0xDEADBEEF.
- RUN, only `dbg_req`, addr 3, data 0x55 → `dbg_gnt`=1 same cycle; next cycle `we_RF`=1, `A3`=3, `WD3`=0x55.
- Both requests held (addrs 7 and 3), `STARVE_LIMIT`=4 → four writes to 7; fifth cycle `pc_en`=0, `wb_stall`=1, `dbg_gnt`=1; next cycle `A3`=3; then writes to 7 resume with `pc_en`=1.
- `rst`=0 when sweep `A3`=10 → outputs reset; after release the sweep restarts at `A3`=0 and runs the full 32 cycles.
- `wb_req`=1 during INIT → `wb_stall`=1; no write to `wb_addr` occurs; init pattern is unaffected.
